// File: rtl/variable_fa.sv
// variable_fa: N-bit ripple-carry adder with registered sum and carry-out, async active-low reset
module variable_fa #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0]   c;
  logic [N-1:0] s;
  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= s;
      cout <= c[N];
    end
  end
endmodule

// File: tb/tb_variable_fa.sv
// tb_variable_fa: random and directed checks of variable_fa at N=4, N=1 and N=8
module tb_variable_fa;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic       c4 = 1'b0, co4;
  logic [0:0] a1 = '0, b1 = '0, s1;
  logic       c1 = 1'b0, co1;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       c8 = 1'b0, co8;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  variable_fa #(.N(4)) u_n4 (.clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(c4), .sum(s4), .cout(co4));
  variable_fa #(.N(1)) u_n1 (.clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(c1), .sum(s1), .cout(co1));
  variable_fa #(.N(8)) u_n8 (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(c8), .sum(s8), .cout(co8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r4();
    return {27'b0, co4, s4};
  endfunction
  function automatic logic [31:0] r1();
    return {30'b0, co1, s1};
  endfunction
  function automatic logic [31:0] r8();
    return {23'b0, co8, s8};
  endfunction

  task automatic rand_ops();
    a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
    a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
  endtask

  task automatic tick(input string tag);
    int e4, e1, e8;
    e4 = a4 + b4 + c4;
    e1 = a1 + b1 + c1;
    e8 = a8 + b8 + c8;
    @(posedge clk);
    #1;
    check({tag, "_n4"}, r4(), e4);
    check({tag, "_n1"}, r1(), e1);
    check({tag, "_n8"}, r8(), e8);
  endtask

  logic [3:0] da[7] = '{4'b0000, 4'b0110, 4'b0001, 4'b1101, 4'b1111, 4'b1111, 4'b1111};
  logic [3:0] db[7] = '{4'b0000, 4'b0101, 4'b1001, 4'b0111, 4'b1111, 4'b0000, 4'b0000};
  logic       dc[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [4:0] de[7] = '{5'b0_0000, 5'b0_1011, 5'b0_1010, 5'b1_0100, 5'b1_1110, 5'b1_0000, 5'b0_1111};

  initial begin
    a4 = 4'hf; b4 = 4'hf; c4 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a8 = 8'hff; b8 = 8'hff; c8 = 1'b1;
    #1;
    check("rst_init_n4", r4(), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_n4", r4(), 0);
      check("rst_hold_n1", r1(), 0);
      check("rst_hold_n8", r8(), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel_n4", r4(), 32'h1f);
    check("rst_rel_n8", r8(), 32'h1ff);
    for (int i = 0; i < 7; i++) begin
      a4 = da[i]; b4 = db[i]; c4 = dc[i];
      tick("dir");
      check("dir_const", r4(), {27'b0, de[i]});
    end
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      tick("exh");
    end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] p4, p8;
      rand_ops();
      tick("rnd");
      p4 = r4();
      p8 = r8();
      rand_ops();
      #3;
      check("hold_n4", r4(), p4);
      check("hold_n8", r8(), p8);
    end
    for (int i = 0; i < 4; i++) begin
      a4 = 4'hf; b4 = 4'h1; c4 = 1'b1;
      a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
      a8 = 8'hf0; b8 = 8'h1f; c8 = 1'b0;
      tick("pre_pulse");
      #1;
      rst_n = 1'b0;
      #1;
      check("pulse_n4", r4(), 0);
      check("pulse_n1", r1(), 0);
      check("pulse_n8", r8(), 0);
      #1;
      rst_n = 1'b1;
      rand_ops();
      tick("post_pulse");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
